// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the serial sequence detector.
package seqdet_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int                             DEFAULT_PATTERN_LEN = 4;
  localparam logic [DEFAULT_PATTERN_LEN-1:0] DEFAULT_PATTERN     = 4'b1011;
  localparam int                             DEFAULT_COUNT_W     = 8;
  localparam int                             BITS_SEEN_MAX       = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky "reached max" flag.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Next count: clear wins, increment stops at MAX; flag latches once MAX is reached.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc && (count_q != MAX)) begin
        count_d = count_q + 1'b1;
      end
      sat_d = sat_q | (count_d == MAX);
    end
  end

  // Counter and flag registers, asynchronously reset.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/overlap_sequence_detector.sv
// Serial pattern detector: shifts in one bit per bit_valid strobe, matches the
// last PATTERN_LEN bits against PATTERN, and keeps saturating match / bit counts.
module overlap_sequence_detector
  import seqdet_pkg::*;
#(
  parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = DEFAULT_PATTERN,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     COUNT_W     = DEFAULT_COUNT_W
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               clear,
  output logic [COUNT_W-1:0] pattern_count,
  output logic               match_pulse,
  output logic               count_sat,
  output logic [7:0]         bits_seen,
  output logic               state
);

  localparam int                FILL_W    = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]      fill_q, fill_d, fill_next;
  state_t                 state_q, state_d;
  logic                   match_pulse_q, match_pulse_d;
  logic                   accept, match, restart;
  logic                   bits_full;

  // History shift, fill tracking and the match compare against the post-shift history.
  always_comb begin
    accept     = bit_valid & ~clear;
    hist_shift = {hist_q[PATTERN_LEN-2:0], bit_in};
    fill_next  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match      = accept && (hist_shift == PATTERN) && (fill_next == FILL_FULL);
    // Non-overlapping mode discards the matched bits so the next search starts clean.
    restart    = match && !OVERLAP;
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (clear || restart) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = fill_next;
    end
    match_pulse_d = match;
  end

  // Next-state: FILL until the history is full, TRACK afterwards.
  always_comb begin
    state_d = state_q;
    if (clear || restart) begin
      state_d = FILL;
    end else if (accept) begin
      case (state_q)
        FILL:    if (fill_next == FILL_FULL) state_d = TRACK;
        TRACK:   state_d = TRACK;
        default: state_d = FILL;
      endcase
    end
  end

  // State, history, fill and match pulse registers.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      hist_q        <= '0;
      fill_q        <= '0;
      match_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    state       = logic'(state_q);
    match_pulse = match_pulse_q;
  end

  sat_counter #(
    .WIDTH (COUNT_W),
    .MAX   ({COUNT_W{1'b1}})
  ) u_match_count (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .clr          (clear),
    .inc          (match),
    .count        (pattern_count),
    .sat          (count_sat)
  );

  sat_counter #(
    .WIDTH (8),
    .MAX   (8'(BITS_SEEN_MAX))
  ) u_bits_seen (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .clr          (clear),
    .inc          (accept & ~bits_full),
    .count        (bits_seen),
    .sat          (bits_full)
  );

endmodule

// File: tb/tb_overlap_sequence_detector.sv
// Directed bench for overlap_sequence_detector: three instances (1011 overlap,
// 1011 non-overlap, 1111 overlap) share one stimulus stream; a bit-list model
// pushes expected outputs into per-instance queues that are popped after each edge.
module tb_overlap_sequence_detector;

  typedef struct packed {
    logic       pulse;
    logic [7:0] cnt;
    logic       sat;
    logic [7:0] bits;
    logic       st;
  } exp_t;

  logic clock_100Mhz = 1'b0;
  logic reset        = 1'b1;
  logic bit_in       = 1'b0;
  logic bit_valid    = 1'b0;
  logic clear        = 1'b0;

  logic [7:0] pc [3];
  logic       mp [3];
  logic       cs [3];
  logic [7:0] bs [3];
  logic       st [3];

  always #5 clock_100Mhz = ~clock_100Mhz;

  overlap_sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u_ov (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .pattern_count(pc[0]), .match_pulse(mp[0]), .count_sat(cs[0]), .bits_seen(bs[0]), .state(st[0]));

  overlap_sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u_nov (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .pattern_count(pc[1]), .match_pulse(mp[1]), .count_sat(cs[1]), .bits_seen(bs[1]), .state(st[1]));

  overlap_sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .COUNT_W(8)) u_ones (
    .clock_100Mhz(clock_100Mhz), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .pattern_count(pc[2]), .match_pulse(mp[2]), .count_sat(cs[2]), .bits_seen(bs[2]), .state(st[2]));

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: the raw list of bits accepted since the last restart.
  logic [3:0] m_pat [3] = '{4'b1011, 4'b1011, 4'b1111};
  bit         m_ov  [3] = '{1'b1, 1'b0, 1'b1};
  bit         m_bits_q [3][$];
  int         m_cnt  [3];
  bit         m_sat  [3];
  int         m_seen [3];
  exp_t       sbq    [3][$];

  task automatic cmp(input string tag, input int idx, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_bits_q[i].delete();
      m_cnt[i]  = 0;
      m_sat[i]  = 1'b0;
      m_seen[i] = 0;
    end
  endtask

  // Advance the model for one cycle and queue the expected post-edge outputs.
  task automatic model_push(input logic bv, input logic b, input logic clr);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bit   hit = 1'b0;
      if (clr) begin
        m_bits_q[i].delete();
        m_cnt[i]  = 0;
        m_sat[i]  = 1'b0;
        m_seen[i] = 0;
      end else if (bv) begin
        m_bits_q[i].push_back(b);
        if (m_seen[i] < 255) m_seen[i]++;
        if (m_bits_q[i].size() >= 4) begin
          hit = 1'b1;
          for (int k = 0; k < 4; k++)
            if (m_bits_q[i][m_bits_q[i].size() - 4 + k] != m_pat[i][3-k]) hit = 1'b0;
        end
        if (hit) begin
          if (m_cnt[i] < 255) m_cnt[i]++;
          if (m_cnt[i] == 255) m_sat[i] = 1'b1;
          if (!m_ov[i]) m_bits_q[i].delete();
        end
        if (m_bits_q[i].size() > 8) void'(m_bits_q[i].pop_front());
      end
      e.pulse = hit;
      e.cnt   = 8'(m_cnt[i]);
      e.sat   = m_sat[i];
      e.bits  = 8'(m_seen[i]);
      e.st    = (m_bits_q[i].size() >= 4);
      sbq[i].push_back(e);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (sbq[i].size() == 0) begin
        cmp("scoreboard_empty", i, 0, 1);
      end else begin
        e = sbq[i].pop_front();
        cmp("match_pulse",   i, int'(mp[i]), int'(e.pulse));
        cmp("pattern_count", i, int'(pc[i]), int'(e.cnt));
        cmp("count_sat",     i, int'(cs[i]), int'(e.sat));
        cmp("bits_seen",     i, int'(bs[i]), int'(e.bits));
        cmp("state",         i, int'(st[i]), int'(e.st));
      end
    end
  endtask

  task automatic apply(input logic bv, input logic b, input logic clr);
    bit_valid = bv;
    bit_in    = b;
    clear     = clr;
    model_push(bv, b, clr);
    @(posedge clock_100Mhz);
    #1;
    bit_valid = 1'b0;
    clear     = 1'b0;
    check_all();
  endtask

  task automatic send(input logic b);
    apply(1'b1, b, 1'b0);
  endtask

  logic [6:0] stream7;

  initial begin
    model_reset();
    // Reset held across two edges, then released; then 100 idle cycles.
    repeat (2) @(posedge clock_100Mhz);
    #1;
    model_push(1'b0, 1'b0, 1'b0);
    check_all();
    reset = 1'b0;
    for (int n = 0; n < 100; n++) apply(1'b0, 1'b1, 1'b0);

    // Stream 1,0,1,1,0,1,1: overlap gives 2 matches, non-overlap gives 1.
    stream7 = 7'b1011011;
    for (int n = 6; n >= 0; n--) begin
      send(stream7[n]);
      if (n == 3) cmp("pulse_after_bit4_nov", 1, int'(mp[1]), 1);
      if (n == 3) cmp("state_fill_after_bit4_nov", 1, int'(st[1]), 0);
      if (n == 0) cmp("pulse_after_bit7_ov", 0, int'(mp[0]), 1);
    end
    cmp("final_count_ov", 0, int'(pc[0]), 2);
    cmp("final_count_nov", 1, int'(pc[1]), 1);
    cmp("final_bits_seen", 0, int'(bs[0]), 7);
    apply(1'b0, 1'b0, 1'b0);
    cmp("pulse_one_cycle", 0, int'(mp[0]), 0);

    // Clear, then 1,0,1, then clear colliding with a valid 1, then 1,0,1,1.
    apply(1'b0, 1'b0, 1'b1);
    send(1'b1); send(1'b0); send(1'b1);
    apply(1'b1, 1'b1, 1'b1);
    cmp("clear_no_pulse", 0, int'(mp[0]), 0);
    cmp("clear_count", 0, int'(pc[0]), 0);
    cmp("clear_bits", 0, int'(bs[0]), 0);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    cmp("count_after_clear", 0, int'(pc[0]), 1);

    // Async reset mid-cycle after 1,0,1: outputs drop without a clock edge.
    apply(1'b0, 1'b0, 1'b1);
    send(1'b1); send(1'b0); send(1'b1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    model_push(1'b0, 1'b0, 1'b0);
    check_all();
    @(posedge clock_100Mhz);
    #1;
    reset = 1'b0;
    send(1'b1);
    cmp("no_match_across_reset", 0, int'(mp[0]), 0);

    // 300 back-to-back 1s: pulse every cycle for 1111, count saturates at 255.
    apply(1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 300; n++) begin
      send(1'b1);
      if (n == 257) begin
        cmp("count_before_sat", 2, int'(pc[2]), 254);
        cmp("sat_not_yet", 2, int'(cs[2]), 0);
      end
      if (n == 258) cmp("sat_at_255th", 2, int'(cs[2]), 1);
    end
    cmp("ones_count_final", 2, int'(pc[2]), 255);
    cmp("ones_sat_final", 2, int'(cs[2]), 1);
    cmp("ones_bits_final", 2, int'(bs[2]), 255);
    cmp("ones_pulse_at_sat", 2, int'(mp[2]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
